// File: rtl/mem16_wide_master.sv
// mem16_wide_master
//   Bus initiator for the 16-bit word-addressed register bus. One host request for a
//   1..4-word register becomes a series of single-word read or write strobes. Each strobe
//   waits for its completion, and the wide value is split (writes) or assembled (reads)
//   in big-endian word order: word 0 is the most significant 16 bits.
//
// Ports
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   req_i, we_i     host request / direction (1 = write), sampled while ready_o is high
//   addr_i          base word address; word k goes to addr_i + k (wraps modulo 2^19)
//   nwords_i        number of words minus one
//   wdata_i         write value, right-aligned in the low 16*N bits
//   ready_o         idle, request can be accepted
//   done_o, err_o   one-cycle end-of-transfer pulse; err_o = 1 when aborted by timeout
//   rdata_o         assembled read value, held until the next accepted request
//   bus_*           word address, write data, read/write strobes, slave completions
//
// Parameter
//   TIMEOUT         cycles allowed from a strobe to its completion (1..65535)

module mem16_wide_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [18:0] addr_i,
    input  logic [1:0]  nwords_i,
    input  logic [63:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [63:0] rdata_o,
    output logic [18:0] bus_addr_o,
    output logic [15:0] bus_wr_data_o,
    output logic        bus_rd_mem_o,
    output logic        bus_wr_mem_o,
    input  logic [15:0] bus_rd_data_i,
    input  logic        bus_rd_done_i,
    input  logic        bus_wr_done_i
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    // Last counter value that may still accept a completion.
    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [18:0] base_q, base_d;
    logic [1:0]  nwords_q, nwords_d;
    logic [63:0] wdata_q, wdata_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] tmo_q, tmo_d;
    logic [63:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [18:0] bus_addr_q, bus_addr_d;
    logic [15:0] bus_wr_data_q, bus_wr_data_d;
    logic        rd_mem_q, rd_mem_d;
    logic        wr_mem_q, wr_mem_d;

    logic        match;
    logic [1:0]  cur_slot;
    logic [1:0]  next_slot;

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        base_d        = base_q;
        nwords_d      = nwords_q;
        wdata_d       = wdata_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        rdata_d       = rdata_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_mem_d      = 1'b0;
        wr_mem_d      = 1'b0;

        match     = we_q ? bus_wr_done_i : bus_rd_done_i;
        // Word k lives in 16-bit slot (N-1-k) of the wide value.
        cur_slot  = nwords_q - idx_q;
        next_slot = cur_slot - 2'd1;

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    we_d       = we_i;
                    base_d     = addr_i;
                    nwords_d   = nwords_i;
                    wdata_d    = wdata_i;
                    idx_d      = 2'd0;
                    tmo_d      = 16'd0;
                    rdata_d    = 64'd0;
                    bus_addr_d = addr_i;
                    if (we_i) begin
                        bus_wr_data_d = wdata_i[{nwords_i, 4'b0000} +: 16];
                    end
                    rd_mem_d   = ~we_i;
                    wr_mem_d   = we_i;
                    state_d    = StIssue;
                end
            end

            StIssue: begin
                // The strobe cycle itself counts toward the timeout; completions seen
                // here are ignored, so a timeout of one cycle can never be met.
                if (TIMEOUT <= 1) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d   = tmo_q + 16'd1;
                    state_d = StWait;
                end
            end

            StWait: begin
                if (match) begin
                    if (!we_q) begin
                        rdata_d[{cur_slot, 4'b0000} +: 16] = bus_rd_data_i;
                    end
                    if (idx_q == nwords_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        tmo_d      = 16'd0;
                        bus_addr_d = base_q + 19'(idx_q) + 19'd1;
                        if (we_q) begin
                            bus_wr_data_d = wdata_q[{next_slot, 4'b0000} +: 16];
                        end
                        rd_mem_d   = ~we_q;
                        wr_mem_d   = we_q;
                        state_d    = StIssue;
                    end
                end else if (tmo_q == TmoLast) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            we_q          <= 1'b0;
            base_q        <= 19'd0;
            nwords_q      <= 2'd0;
            wdata_q       <= 64'd0;
            idx_q         <= 2'd0;
            tmo_q         <= 16'd0;
            rdata_q       <= 64'd0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            bus_addr_q    <= 19'd0;
            bus_wr_data_q <= 16'd0;
            rd_mem_q      <= 1'b0;
            wr_mem_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            base_q        <= base_d;
            nwords_q      <= nwords_d;
            wdata_q       <= wdata_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            rdata_q       <= rdata_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            err_q         <= err_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_mem_q      <= rd_mem_d;
            wr_mem_q      <= wr_mem_d;
        end
    end

    assign ready_o       = ready_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wr_data_o = bus_wr_data_q;
    assign bus_rd_mem_o  = rd_mem_q;
    assign bus_wr_mem_o  = wr_mem_q;

endmodule
